// File: rtl/fb_arbiter_if.sv
// Display-read / pixel-write client bus plus the framebuffer RAM port, as one bundle.
// slave = arbiter side, master = clients and RAM (the testbench drives both).
interface fb_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, ram_rdata,
    output rd_ready, rd_data, rd_valid, wr_ready,
    output ram_addr, ram_wdata, ram_we, ram_re
  );

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, ram_rdata,
    input  rd_ready, rd_data, rd_valid, wr_ready,
    input  ram_addr, ram_wdata, ram_we, ram_re
  );
endinterface

// File: rtl/fb_arbiter.sv
// Framebuffer arbiter: display reads win unless the writer has waited MAX_WAIT cycles.
// Read data returns 3 cycles after accept; rejected requests must be held by the client.
module fb_arbiter #(
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 8,
  parameter int FB_DEPTH = 307200,
  parameter int MAX_WAIT = 15
) (
  input  logic           clk_50,
  input  logic           rst,
  fb_arbiter_if.slave    bus,
  output logic           err_oob
);
  localparam int WCW = (MAX_WAIT < 15) ? 4 : $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0]    WAIT_MAX = WCW'(MAX_WAIT);
  localparam logic [ADDR_W-1:0] DEPTH    = ADDR_W'(FB_DEPTH);

  logic [WCW-1:0] wait_cnt;
  logic [WCW-1:0] wait_nxt;
  logic           force_wr;
  logic           rd_acc;
  logic           wr_acc;
  logic           rd_oob;
  logic           wr_oob;

  // Read tag pipeline: s1 aligns with the RAM command, s2 with ram_rdata.
  logic s1_rd, s1_oob;
  logic s2_rd, s2_oob;

  always_comb begin
    force_wr = bus.wr_req && (wait_cnt == WAIT_MAX);
    rd_acc   = !rst && bus.rd_req && !force_wr;
    wr_acc   = !rst && bus.wr_req && (!bus.rd_req || force_wr);
    rd_oob   = bus.rd_addr >= DEPTH;
    wr_oob   = bus.wr_addr >= DEPTH;
    wait_nxt = '0;
    if (bus.wr_req && !wr_acc) begin
      wait_nxt = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 1'b1;
    end
  end

  assign bus.rd_ready = rd_acc;
  assign bus.wr_ready = wr_acc;

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      wait_cnt      <= '0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
      bus.ram_we    <= 1'b0;
      bus.ram_re    <= 1'b0;
      err_oob       <= 1'b0;
      s1_rd         <= 1'b0;
      s1_oob        <= 1'b0;
      s2_rd         <= 1'b0;
      s2_oob        <= 1'b0;
      bus.rd_valid  <= 1'b0;
      bus.rd_data   <= '0;
    end else begin
      wait_cnt   <= wait_nxt;
      bus.ram_re <= rd_acc && !rd_oob;
      bus.ram_we <= wr_acc && !wr_oob;
      // Address and write data hold on idle and out-of-bounds slots.
      if (rd_acc && !rd_oob) begin
        bus.ram_addr <= bus.rd_addr;
      end else if (wr_acc && !wr_oob) begin
        bus.ram_addr  <= bus.wr_addr;
        bus.ram_wdata <= bus.wr_data;
      end
      if ((rd_acc && rd_oob) || (wr_acc && wr_oob)) begin
        err_oob <= 1'b1;
      end
      s1_rd        <= rd_acc;
      s1_oob       <= rd_oob;
      s2_rd        <= s1_rd;
      s2_oob       <= s1_oob;
      bus.rd_valid <= s2_rd;
      if (s2_rd) begin
        bus.rd_data <= s2_oob ? '0 : bus.ram_rdata;
      end
    end
  end
endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: grant table, directed corner sequences, then random traffic vs a transaction-level model.
module tb_fb_arbiter;
  localparam int ADDR_W   = 19;
  localparam int DATA_W   = 8;
  localparam int FB_DEPTH = 307200;
  localparam int MAX_WAIT = 15;

  logic clk_50 = 1'b0;
  logic rst;
  logic err_oob;

  fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fb_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FB_DEPTH(FB_DEPTH), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk_50 (clk_50),
    .rst    (rst),
    .bus    (bus),
    .err_oob(err_oob)
  );

  always #10 clk_50 = ~clk_50;

  function automatic logic [7:0] pat(input int a);
    return (a == 5) ? 8'h3C : 8'(a * 7 + 3);
  endfunction

  // Synchronous single-port RAM, one-cycle read latency; loaded on the first edge (inside reset).
  logic [7:0] mem [0:FB_DEPTH-1];
  bit mem_loaded = 1'b0;
  always @(posedge clk_50) begin
    if (!mem_loaded) begin
      for (int i = 0; i < FB_DEPTH; i++) mem[i] <= pat(i);
      mem_loaded <= 1'b1;
    end else begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      if (bus.ram_re) bus.ram_rdata <= mem[bus.ram_addr];
    end
  end

  // Reference model: memory image as seen in acceptance order, expected returns by due cycle.
  typedef struct { int due; logic [7:0] d; } rexp_t;
  logic [7:0]        ref_mem [0:FB_DEPTH-1];
  rexp_t             rdq[$];
  int                cyc;
  int                wblk;
  bit                m_err;
  bit                e_re, e_we;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_wdata;
  int                total, bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_cycle();
    bit erd, ewr;
    logic [7:0] d;
    cyc++;
    if (rst) begin
      chk("rst_rd_ready", 32'(bus.rd_ready), 0);
      chk("rst_wr_ready", 32'(bus.wr_ready), 0);
      chk("rst_rd_valid", 32'(bus.rd_valid), 0);
      chk("rst_rd_data", 32'(bus.rd_data), 0);
      chk("rst_ram_re", 32'(bus.ram_re), 0);
      chk("rst_ram_we", 32'(bus.ram_we), 0);
      chk("rst_ram_addr", 32'(bus.ram_addr), 0);
      chk("rst_ram_wdata", 32'(bus.ram_wdata), 0);
      chk("rst_err_oob", 32'(err_oob), 0);
      rdq.delete();
      wblk = 0; m_err = 0; e_re = 0; e_we = 0; e_addr = '0; e_wdata = '0;
      return;
    end
    chk("ram_re", 32'(bus.ram_re), 32'(e_re));
    chk("ram_we", 32'(bus.ram_we), 32'(e_we));
    chk("ram_addr", 32'(bus.ram_addr), 32'(e_addr));
    chk("ram_wdata", 32'(bus.ram_wdata), 32'(e_wdata));
    if (rdq.size() > 0 && rdq[0].due == cyc) begin
      chk("rd_valid", 32'(bus.rd_valid), 1);
      chk("rd_data", 32'(bus.rd_data), 32'(rdq[0].d));
      void'(rdq.pop_front());
    end else begin
      chk("rd_valid_idle", 32'(bus.rd_valid), 0);
    end
    chk("err_oob", 32'(err_oob), 32'(m_err));
    erd = bus.rd_req && !(bus.wr_req && wblk >= MAX_WAIT);
    ewr = bus.wr_req && !erd;
    chk("rd_ready", 32'(bus.rd_ready), 32'(erd));
    chk("wr_ready", 32'(bus.wr_ready), 32'(ewr));
    wblk = (bus.wr_req && !ewr) ? wblk + 1 : 0;
    e_re = 0; e_we = 0;
    if (erd) begin
      if (int'(bus.rd_addr) < FB_DEPTH) begin
        e_re = 1; e_addr = bus.rd_addr; d = ref_mem[bus.rd_addr];
      end else begin
        m_err = 1; d = 8'h00;
      end
      rdq.push_back('{cyc + 3, d});
    end
    if (ewr) begin
      if (int'(bus.wr_addr) < FB_DEPTH) begin
        e_we = 1; e_addr = bus.wr_addr; e_wdata = bus.wr_data;
        ref_mem[bus.wr_addr] = bus.wr_data;
      end else begin
        m_err = 1;
      end
    end
  endtask

  task automatic sample();
    @(negedge clk_50);
    check_cycle();
  endtask

  task automatic advance();
    @(posedge clk_50);
    #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic drive(input logic rr, input logic [ADDR_W-1:0] ra, input logic wr,
                       input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd);
    bus.rd_req = rr; bus.rd_addr = ra; bus.wr_req = wr; bus.wr_addr = wa; bus.wr_data = wd;
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    if ($urandom_range(15, 0) == 0) return ADDR_W'($urandom_range(FB_DEPTH + 1, FB_DEPTH - 2));
    return ADDR_W'($urandom_range(63, 0));
  endfunction

  typedef struct {
    logic rr; logic [ADDR_W-1:0] ra; logic wr; logic [ADDR_W-1:0] wa; logic [7:0] wd;
    logic er; logic ew;
  } vec_t;
  vec_t tbl [10];

  initial begin
    int first, n;
    total = 0; bad = 0; cyc = 0; wblk = 0; m_err = 0;
    e_re = 0; e_we = 0; e_addr = '0; e_wdata = '0;
    for (int i = 0; i < FB_DEPTH; i++) ref_mem[i] = pat(i);
    drive(0, '0, 0, '0, '0);
    rst = 1'b1;
    advance();
    step();
    rst = 1'b0;

    // Grant decisions from a clean wait counter.
    tbl[0] = '{1'b0, 19'd0,      1'b0, 19'd0,  8'h00, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 19'd10,     1'b0, 19'd0,  8'h00, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 19'd0,      1'b1, 19'd20, 8'h5A, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 19'd11,     1'b1, 19'd21, 8'h5B, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 19'd12,     1'b1, 19'd21, 8'h5B, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 19'd0,      1'b1, 19'd21, 8'h5B, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 19'd13,     1'b1, 19'd22, 8'h77, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 19'd0,      1'b0, 19'd0,  8'h00, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 19'd14,     1'b1, 19'd23, 8'h99, 1'b1, 1'b0};
    tbl[9] = '{1'b1, 19'd307199, 1'b0, 19'd0,  8'h00, 1'b1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].rr, tbl[i].ra, tbl[i].wr, tbl[i].wa, tbl[i].wd);
      sample();
      chk($sformatf("tbl%0d_rd_ready", i), 32'(bus.rd_ready), 32'(tbl[i].er));
      chk($sformatf("tbl%0d_wr_ready", i), 32'(bus.wr_ready), 32'(tbl[i].ew));
      advance();
    end
    drive(0, '0, 0, '0, '0);
    repeat (4) step();

    // Single read of addr 5: command at T+1, data at T+3.
    drive(1, 19'd5, 0, '0, '0);
    step();
    drive(0, '0, 0, '0, '0);
    sample();
    chk("a_ram_re", 32'(bus.ram_re), 1);
    chk("a_ram_addr", 32'(bus.ram_addr), 5);
    advance();
    sample();
    chk("a_no_early_valid", 32'(bus.rd_valid), 0);
    advance();
    sample();
    chk("a_rd_valid", 32'(bus.rd_valid), 1);
    chk("a_rd_data", 32'(bus.rd_data), 32'h3C);
    advance();
    sample();
    chk("a_single_pulse", 32'(bus.rd_valid), 0);
    advance();

    // Write then read the same address on the next cycle.
    drive(0, '0, 1, 19'd100, 8'hA5);
    step();
    drive(1, 19'd100, 0, '0, '0);
    step();
    drive(0, '0, 0, '0, '0);
    step();
    step();
    sample();
    chk("b_raw_valid", 32'(bus.rd_valid), 1);
    chk("b_raw_data", 32'(bus.rd_data), 32'hA5);
    advance();
    repeat (2) step();

    // Starved writer is forced ahead on its 16th pending cycle.
    drive(1, 19'd7, 1, 19'd200, 8'h11);
    first = 0;
    for (int k = 1; k <= 20; k++) begin
      sample();
      if (first == 0 && bus.wr_ready) begin
        first = k;
        chk("c_rd_ready_forced", 32'(bus.rd_ready), 0);
      end
      advance();
      if (first != 0) break;
    end
    chk("c_first_wr_grant", 32'(first), 16);
    sample();
    chk("c_display_wins_again", 32'(bus.rd_ready), 1);
    chk("c_wr_blocked_again", 32'(bus.wr_ready), 0);
    advance();
    drive(0, '0, 0, '0, '0);
    repeat (4) step();

    // Out-of-bounds read.
    drive(1, 19'd307200, 0, '0, '0);
    step();
    drive(0, '0, 0, '0, '0);
    sample();
    chk("d_no_ram_re", 32'(bus.ram_re), 0);
    chk("d_err_set", 32'(err_oob), 1);
    advance();
    step();
    sample();
    chk("d_oob_valid", 32'(bus.rd_valid), 1);
    chk("d_oob_data", 32'(bus.rd_data), 0);
    advance();
    repeat (5) step();
    sample();
    chk("d_err_sticky", 32'(err_oob), 1);
    advance();

    // Reset with reads in flight.
    drive(1, 19'd1, 0, '0, '0);
    step();
    drive(1, 19'd2, 0, '0, '0);
    step();
    drive(1, 19'd3, 0, '0, '0);
    rst = 1'b1;
    sample();
    chk("e_rd_ready_in_rst", 32'(bus.rd_ready), 0);
    chk("e_err_cleared", 32'(err_oob), 0);
    advance();
    step();
    rst = 1'b0;
    drive(0, '0, 0, '0, '0);
    n = 0;
    for (int k = 0; k < 6; k++) begin
      sample();
      if (bus.rd_valid) n++;
      advance();
    end
    chk("e_flushed_valids", 32'(n), 0);
    drive(1, 19'd2, 0, '0, '0);
    step();
    drive(0, '0, 0, '0, '0);
    step();
    step();
    sample();
    chk("e_post_rst_valid", 32'(bus.rd_valid), 1);
    chk("e_post_rst_data", 32'(bus.rd_data), 32'h11);
    advance();

    // Writer alone: ten back-to-back writes.
    n = 0;
    for (int k = 0; k <= 10; k++) begin
      if (k < 10) drive(0, '0, 1, ADDR_W'(1000 + k), 8'(k * 3 + 1));
      else        drive(0, '0, 0, '0, '0);
      sample();
      if (k < 10) chk($sformatf("f_wr_ready%0d", k), 32'(bus.wr_ready), 1);
      if (bus.ram_we && bus.ram_addr == ADDR_W'(1000 + k - 1) && bus.ram_wdata == 8'((k - 1) * 3 + 1)) n++;
      advance();
    end
    chk("f_we_pulses", 32'(n), 10);
    repeat (2) step();

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      drive(1'($urandom_range(3, 0) != 0), rand_addr(), 1'($urandom_range(1, 0)),
            rand_addr(), 8'($urandom));
      step();
    end
    drive(0, '0, 0, '0, '0);
    repeat (5) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
